// File: rtl/a2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : a2s_pkg                                                         |
// | Purpose  : Shared constants for the AXI-read-to-stream prefetch controller:|
// |            fetch FSM state encoding, AXI OKAY response code and a          |
// |            constant clog2 helper used to size pointers.                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package a2s_pkg;

  // Fetch FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Smallest r with 2**r >= value; evaluated at elaboration time only
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a2s_bank_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : a2s_bank_tracker                                                |
// | Purpose  : Holds one valid flag per prefetch buffer bank. A bank is set    |
// |            when its burst has been fully written and cleared once the      |
// |            consumer has read its last word. flush clears every flag.       |
// | Ports    : clk, rst (async, active-high)                                   |
// |            flush            clear all flags (highest priority)             |
// |            set_en/set_idx   mark bank set_idx valid                        |
// |            clr_en/clr_idx   mark bank clr_idx free                         |
// |            bank_valid       current flag vector                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module a2s_bank_tracker
  import a2s_pkg::*;
#(
  parameter int BANK_NUM = 2,
  parameter int NW       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                set_en,
  input  logic [NW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [NW-1:0]       clr_idx,
  output logic [BANK_NUM-1:0] bank_valid
);

  logic [BANK_NUM-1:0] valid_d;
  logic [BANK_NUM-1:0] valid_q;

  // Set wins over clear on the same bank: a clear there can only come from a
  // consumer that ran into a bank still being filled (an underrun), and the
  // freshly written data must not be discarded.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < BANK_NUM; i++) begin
      if (clr_en && (clr_idx == NW'(i))) begin
        valid_d[i] = 1'b0;
      end
      if (set_en && (set_idx == NW'(i))) begin
        valid_d[i] = 1'b1;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bank_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/a2s_prefetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : a2s_prefetch_ctrl                                               |
// | Purpose  : AXI-read-to-stream controller with BANK_NUM-bank prefetch.      |
// |            Issues INCR bursts from an OCM ring, writes the beats into an   |
// |            external banked buffer and frees each bank once the consumer    |
// |            has read past it. Flags protocol errors and consumer underrun.  |
// | Ports    : AXI_clk, rst (async, active-high), sync (sync restart)          |
// |            Oen/Oaddr            consumer read strobe / buffer read address |
// |            a2s_cnt              banks consumed since sync                  |
// |            AXI_raddr/arlen/arvalid/arready   AR channel                    |
// |            AXI_rvalid/rready/rlast/rresp     R channel                     |
// |            a2s_addr/a2s_en      buffer write address / enable              |
// |            a2s_err, underrun    sticky status, cleared by sync             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module a2s_prefetch_ctrl
  import a2s_pkg::*;
#(
  parameter logic [31:0] OCM_HADDR = 32'hfffc0000,
  parameter int          OCM_WIDTH = 16,
  parameter int          BURST_LEN = 16,
  parameter int          BANK_NUM  = 2,
  localparam int         BW        = clog2(BURST_LEN),
  localparam int         NW        = clog2(BANK_NUM)
) (
  input  logic             AXI_clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             Oen,
  output logic [NW+BW-1:0] Oaddr,
  output logic [31:0]      a2s_cnt,
  output logic [31:0]      AXI_raddr,
  output logic [7:0]       AXI_arlen,
  output logic             AXI_arvalid,
  input  logic             AXI_arready,
  input  logic             AXI_rvalid,
  output logic             AXI_rready,
  input  logic             AXI_rlast,
  input  logic [1:0]       AXI_rresp,
  output logic [NW+BW-1:0] a2s_addr,
  output logic             a2s_en,
  output logic             a2s_err,
  output logic             underrun
);

  // fetch_idx spans exactly the ring, so its natural overflow is the wrap
  localparam int            FW        = OCM_WIDTH - 2 - BW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NW+BW-1:0] rd_ptr_d,     rd_ptr_q;
  logic [31:0]      cnt_d,        cnt_q;
  logic             underrun_d,   underrun_q;
  logic             err_d,        err_q;
  logic [1:0]       state_d,      state_q;
  logic [NW-1:0]    fill_bank_d,  fill_bank_q;
  logic [FW-1:0]    fetch_idx_d,  fetch_idx_q;
  logic [BW-1:0]    beat_d,       beat_q;
  logic             arvalid_d,    arvalid_q;
  logic             rready_d,     rready_q;
  logic [31:0]      raddr_d,      raddr_q;
  logic             drain_pend_d, drain_pend_q;

  logic [BANK_NUM-1:0] bank_valid;
  logic [NW-1:0]       rd_bank;
  logic [BW-1:0]       rd_word;
  logic                rd_bank_done;
  logic                r_hs;
  logic                fill_done;
  logic [31:0]         fetch_addr;

  assign rd_bank      = rd_ptr_q[NW+BW-1:BW];
  assign rd_word      = rd_ptr_q[BW-1:0];
  assign rd_bank_done = Oen && (rd_word == LAST_BEAT) && !sync;
  assign r_hs         = AXI_rvalid && rready_q;
  // A burst completes on the beat count, not on rlast
  assign fill_done    = (state_q == ST_DATA) && r_hs && (beat_q == LAST_BEAT) && !sync;
  assign fetch_addr   = OCM_HADDR | 32'({fetch_idx_q, {(BW + 2){1'b0}}});

  // ---------------------------------------------------------------------------
  // Bank valid flags
  // ---------------------------------------------------------------------------
  a2s_bank_tracker #(
    .BANK_NUM (BANK_NUM),
    .NW       (NW)
  ) u_bank_tracker (
    .clk        (AXI_clk),
    .rst        (rst),
    .flush      (sync),
    .set_en     (fill_done),
    .set_idx    (fill_bank_q),
    .clr_en     (rd_bank_done),
    .clr_idx    (rd_bank),
    .bank_valid (bank_valid)
  );

  // ---------------------------------------------------------------------------
  // Consumer side: the read pointer never stalls, an empty bank is reported
  // as underrun and the pointer still advances.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    if (sync) begin
      rd_ptr_d   = '0;
      cnt_d      = '0;
      underrun_d = 1'b0;
    end else if (Oen) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (!bank_valid[rd_bank]) begin
        underrun_d = 1'b1;
      end
      if (rd_word == LAST_BEAT) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    raddr_d      = raddr_q;
    beat_d       = beat_q;
    drain_pend_d = drain_pend_q;
    fill_bank_d  = fill_bank_q;
    fetch_idx_d  = fetch_idx_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (!bank_valid[fill_bank_q] && !sync) begin
          state_d   = ST_ADDR;
          arvalid_d = 1'b1;
          raddr_d   = fetch_addr;
        end
      end

      ST_ADDR: begin
        // An issued AR cannot be withdrawn; remember a restart seen while
        // waiting so the burst data gets discarded.
        if (sync) begin
          drain_pend_d = 1'b1;
        end
        if (AXI_arready) begin
          arvalid_d    = 1'b0;
          rready_d     = 1'b1;
          beat_d       = '0;
          drain_pend_d = 1'b0;
          state_d      = (sync || drain_pend_q) ? ST_DRAIN : ST_DATA;
        end
      end

      ST_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 1'b1;
          if ((AXI_rlast != (beat_q == LAST_BEAT)) || (AXI_rresp != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            rready_d = 1'b0;
            state_d  = ST_IDLE;
            if (!sync) begin
              fill_bank_d = fill_bank_q + 1'b1;
              fetch_idx_d = fetch_idx_q + 1'b1;
            end
          end else if (sync) begin
            state_d = ST_DRAIN;
          end
        end else if (sync) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (r_hs) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            rready_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sync) begin
      fill_bank_d = '0;
      fetch_idx_d = '0;
      err_d       = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge AXI_clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      underrun_q   <= 1'b0;
      err_q        <= 1'b0;
      state_q      <= ST_IDLE;
      fill_bank_q  <= '0;
      fetch_idx_q  <= '0;
      beat_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      raddr_q      <= '0;
      drain_pend_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      underrun_q   <= underrun_d;
      err_q        <= err_d;
      state_q      <= state_d;
      fill_bank_q  <= fill_bank_d;
      fetch_idx_q  <= fetch_idx_d;
      beat_q       <= beat_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      raddr_q      <= raddr_d;
      drain_pend_q <= drain_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Oaddr       = rd_ptr_q;
  assign a2s_cnt     = cnt_q;
  assign AXI_raddr   = raddr_q;
  assign AXI_arlen   = 8'(BURST_LEN - 1);
  assign AXI_arvalid = arvalid_q;
  assign AXI_rready  = rready_q;
  assign a2s_addr    = {fill_bank_q, beat_q};
  assign a2s_en      = r_hs && (state_q == ST_DATA);
  assign a2s_err     = err_q;
  assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_a2s_prefetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_a2s_prefetch_ctrl                                            |
// | Purpose  : Self-checking bench for a2s_prefetch_ctrl (BURST_LEN=16,        |
// |            BANK_NUM=2, OCM_WIDTH=8). An AXI read responder pops expected   |
// |            AR addresses and buffer write addresses from scoreboard queues. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_a2s_prefetch_ctrl;

  localparam int          BL   = 16;
  localparam int          BN   = 2;
  localparam int          OW   = 8;
  localparam int          AW   = 5;
  localparam logic [31:0] BASE = 32'hfffc0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic          Oen;
  logic [AW-1:0] Oaddr;
  logic [31:0]   a2s_cnt;
  logic [31:0]   AXI_raddr;
  logic [7:0]    AXI_arlen;
  logic          AXI_arvalid;
  logic          arready;
  logic          rvalid;
  logic          AXI_rready;
  logic          rlast;
  logic [1:0]    rresp;
  logic [AW-1:0] a2s_addr;
  logic          a2s_en;
  logic          a2s_err;
  logic          underrun;

  a2s_prefetch_ctrl #(
    .OCM_HADDR (BASE),
    .OCM_WIDTH (OW),
    .BURST_LEN (BL),
    .BANK_NUM  (BN)
  ) dut (
    .AXI_clk     (clk),
    .rst         (rst),
    .sync        (sync),
    .Oen         (Oen),
    .Oaddr       (Oaddr),
    .a2s_cnt     (a2s_cnt),
    .AXI_raddr   (AXI_raddr),
    .AXI_arlen   (AXI_arlen),
    .AXI_arvalid (AXI_arvalid),
    .AXI_arready (arready),
    .AXI_rvalid  (rvalid),
    .AXI_rready  (AXI_rready),
    .AXI_rlast   (rlast),
    .AXI_rresp   (rresp),
    .a2s_addr    (a2s_addr),
    .a2s_en      (a2s_en),
    .a2s_err     (a2s_err),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int            n_total    = 0;
  int            n_bad      = 0;
  logic [31:0]   ar_q[$];
  logic [AW-1:0] wr_q[$];
  bit            arready_en = 1'b1;
  int            rlast_beat = 15;
  int            rresp_beat = -1;
  int            drain_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // AXI read slave: inputs change on negedge, handshakes are resolved 1ns later
  // for the coming posedge.
  initial begin : responder
    int beat;
    bit busy;
    beat = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy    = 1'b0;
        beat    = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
      end else begin
        arready = arready_en;
        rvalid  = busy;
        rlast   = busy && (beat == rlast_beat);
        rresp   = (busy && (beat == rresp_beat)) ? 2'b10 : 2'b00;
        #1;
        if (AXI_arvalid && arready) begin
          check_val("ar_pending", 32'(ar_q.size() != 0), 32'd1);
          if (ar_q.size() != 0) check_val("ar_addr", AXI_raddr, ar_q.pop_front());
          check_val("arlen", 32'(AXI_arlen), 32'd15);
          busy = 1'b1;
          beat = 0;
        end else if (rvalid && AXI_rready) begin
          if (a2s_en) begin
            check_val("wr_pending", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) check_val("wr_addr", 32'(a2s_addr), 32'(wr_q.pop_front()));
          end else begin
            drain_cnt++;
          end
          beat++;
          if (beat == BL) busy = 1'b0;
        end
      end
    end
  end

  task automatic expect_burst(input logic [31:0] addr, input int bank, input bit keep);
    ar_q.push_back(addr);
    if (keep) begin
      for (int b = 0; b < BL; b++) wr_q.push_back(AW'(bank * BL + b));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_n(input int n);
    Oen = 1'b1;
    repeat (n) @(negedge clk);
    Oen = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while ((ar_q.size() != 0 || wr_q.size() != 0 || AXI_rready || AXI_arvalid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    cycles(4);
    check_val({tag, "_ar_left"}, 32'(ar_q.size()), 32'd0);
    check_val({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_arvalid"},  32'(AXI_arvalid), 32'd0);
    check_val({tag, "_rready"},   32'(AXI_rready),  32'd0);
    check_val({tag, "_a2s_en"},   32'(a2s_en),      32'd0);
    check_val({tag, "_err"},      32'(a2s_err),     32'd0);
    check_val({tag, "_underrun"}, 32'(underrun),    32'd0);
    check_val({tag, "_cnt"},      a2s_cnt,          32'd0);
    check_val({tag, "_oaddr"},    32'(Oaddr),       32'd0);
    check_val({tag, "_raddr"},    AXI_raddr,        32'd0);
    check_val({tag, "_waddr"},    32'(a2s_addr),    32'd0);
  endtask

  initial begin : main
    int n;
    rst  = 1'b1;
    sync = 1'b1;
    Oen  = 1'b0;
    cycles(2);
    check_all_zero("reset");

    // 1: two bursts fill both banks, then idle
    expect_burst(BASE | 32'h00, 0, 1'b1);
    expect_burst(BASE | 32'h40, 1, 1'b1);
    rst = 1'b0;
    cycles(1);
    sync = 1'b0;
    wait_quiet("t1", 200);
    check_val("t1_idle_arvalid", 32'(AXI_arvalid), 32'd0);
    check_val("t1_cnt", a2s_cnt, 32'd0);
    check_val("t1_err", 32'(a2s_err), 32'd0);

    // 2: consume bank0 -> refetch one cycle after the bank is freed
    expect_burst(BASE | 32'h80, 0, 1'b1);
    read_n(16);
    check_val("t2_cnt", a2s_cnt, 32'd1);
    check_val("t2_oaddr", 32'(Oaddr), 32'd16);
    check_val("t2_arvalid_early", 32'(AXI_arvalid), 32'd0);
    @(negedge clk);
    check_val("t2_arvalid", 32'(AXI_arvalid), 32'd1);
    check_val("t2_raddr", AXI_raddr, BASE | 32'h80);
    wait_quiet("t2", 200);
    check_val("t2_underrun", 32'(underrun), 32'd0);

    // 3: keep streaming until the fetch index wraps inside the 256-byte ring
    expect_burst(BASE | 32'hc0, 1, 1'b1);
    expect_burst(BASE | 32'h00, 0, 1'b1);
    read_n(32);
    wait_quiet("t3", 200);
    check_val("t3_cnt", a2s_cnt, 32'd3);
    check_val("t3_oaddr", 32'(Oaddr), 32'd16);
    check_val("t3_err", 32'(a2s_err), 32'd0);
    check_val("t3_underrun", 32'(underrun), 32'd0);

    // 4a: rlast on beat 7 (and missing on beat 15)
    rlast_beat = 7;
    expect_burst(BASE | 32'h00, 0, 1'b1);
    expect_burst(BASE | 32'h40, 1, 1'b1);
    pulse_sync();
    check_val("t4a_cnt_clr", a2s_cnt, 32'd0);
    check_val("t4a_oaddr_clr", 32'(Oaddr), 32'd0);
    wait_quiet("t4a", 200);
    check_val("t4a_err", 32'(a2s_err), 32'd1);
    rlast_beat = 15;

    // 4b: SLVERR on beat 3
    rresp_beat = 3;
    expect_burst(BASE | 32'h00, 0, 1'b1);
    expect_burst(BASE | 32'h40, 1, 1'b1);
    pulse_sync();
    check_val("t4b_err_clr", 32'(a2s_err), 32'd0);
    wait_quiet("t4b", 200);
    check_val("t4b_err", 32'(a2s_err), 32'd1);
    cycles(10);
    check_val("t4b_err_sticky", 32'(a2s_err), 32'd1);
    rresp_beat = -1;

    // 5: AR stalled, consumer runs into an empty bank
    arready_en = 1'b0;
    read_n(32);
    check_val("t5_underrun_pre", 32'(underrun), 32'd0);
    check_val("t5_cnt", a2s_cnt, 32'd2);
    check_val("t5_arvalid", 32'(AXI_arvalid), 32'd1);
    check_val("t5_raddr", AXI_raddr, BASE | 32'h80);
    read_n(1);
    check_val("t5_underrun", 32'(underrun), 32'd1);
    check_val("t5_oaddr", 32'(Oaddr), 32'd1);

    // 6: sync while AR is pending -> AR held, burst drained, restart at base
    pulse_sync();
    check_val("t6_arvalid_hold", 32'(AXI_arvalid), 32'd1);
    check_val("t6_raddr_hold", AXI_raddr, BASE | 32'h80);
    check_val("t6_underrun_clr", 32'(underrun), 32'd0);
    check_val("t6_cnt_clr", a2s_cnt, 32'd0);
    cycles(3);
    check_val("t6_arvalid_hold2", 32'(AXI_arvalid), 32'd1);
    expect_burst(BASE | 32'h80, 0, 1'b0);
    expect_burst(BASE | 32'h00, 0, 1'b1);
    expect_burst(BASE | 32'h40, 1, 1'b1);
    drain_cnt  = 0;
    arready_en = 1'b1;
    wait_quiet("t6", 300);
    check_val("t6_drained", 32'(drain_cnt), 32'd16);

    // 6b: asynchronous reset in the middle of a data burst
    expect_burst(BASE | 32'h80, 0, 1'b1);
    read_n(16);
    check_val("t7_cnt", a2s_cnt, 32'd1);
    n = 0;
    #3;
    while (!a2s_en && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_val("t7_in_data", 32'(a2s_en), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("t7_rst");
    ar_q.delete();
    wr_q.delete();
    cycles(2);
    check_val("t7_rst_hold_arvalid", 32'(AXI_arvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
